// File: rtl/img_ram_arbiter_if.sv
// Bus bundle between the image RAM arbiter and its clients: display read
// port, UART write port, RAM port and upload status.
interface img_ram_arbiter_if #(
    parameter int unsigned AddressWidth = 14,
    parameter int unsigned DataWidth    = 8
);
    logic                    disp_req;
    logic [AddressWidth-1:0] disp_addr;
    logic [DataWidth-1:0]    disp_data;
    logic                    disp_valid;

    logic                    wr_valid;
    logic [DataWidth-1:0]    wr_data;
    logic                    wr_ready;

    logic [AddressWidth-1:0] ram_addr;
    logic                    ram_we;
    logic [DataWidth-1:0]    ram_wdata;
    logic [DataWidth-1:0]    ram_rdata;

    logic [AddressWidth-1:0] wr_count;
    logic                    loading;
    logic                    frame_done;
    logic                    abort;

    // Environment side: requesters, RAM data return, status observers
    modport master (
        output disp_req, disp_addr, wr_valid, wr_data, ram_rdata,
        input  disp_data, disp_valid, wr_ready, ram_addr, ram_we, ram_wdata,
               wr_count, loading, frame_done, abort
    );

    // Arbiter side
    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_data, ram_rdata,
        output disp_data, disp_valid, wr_ready, ram_addr, ram_we, ram_wdata,
               wr_count, loading, frame_done, abort
    );
endinterface

// File: rtl/img_ram_arbiter.sv
// Single-port image RAM arbiter: display reads have absolute priority, UART
// bytes are buffered in a small FIFO and written in raster order on free
// cycles. Tracks full-frame uploads with wrap, done pulse and idle timeout.
module img_ram_arbiter #(
    parameter int unsigned AddressWidth   = 14,
    parameter int unsigned DataWidth      = 8,
    parameter int unsigned PIXELS         = 10000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input logic              clk_in,
    input logic              reset,
    img_ram_arbiter_if.slave bus
);
    localparam int unsigned PtrWidth = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntWidth = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES);

    localparam logic [AddressWidth-1:0] LastPixel = AddressWidth'(PIXELS - 1);
    localparam logic [TmoWidth-1:0]     TmoLast   = TmoWidth'(TIMEOUT_CYCLES - 1);
    localparam logic [CntWidth-1:0]     FifoFull  = CntWidth'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DataWidth-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PtrWidth-1:0]     rd_ptr, wr_ptr;
    logic [CntWidth-1:0]     fifo_cnt;
    logic [TmoWidth-1:0]     tmo_cnt, tmo_next;
    logic [AddressWidth-1:0] wr_count_q;
    logic                    rd_pipe;
    logic [DataWidth-1:0]    disp_data_q;
    logic                    disp_valid_q;
    logic                    loading_q, frame_done_q, abort_q;

    logic fifo_full, fifo_empty, push, pop_raw, pop, flush;
    logic last_raw, last_write, tmo_hit;

    // Grant and FIFO control; the raw grant ignores the abort flush so the
    // timeout decision has no combinational loop through the pop.
    assign fifo_full  = (fifo_cnt == FifoFull);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = bus.wr_valid && !fifo_full;
    assign pop_raw    = !reset && !bus.disp_req && !fifo_empty;
    assign last_raw   = pop_raw && (wr_count_q == LastPixel);
    assign tmo_hit    = (state == LOAD) && (tmo_cnt == TmoLast) && !push && !last_raw;
    assign flush      = tmo_hit || (state == ABORT);
    assign pop        = pop_raw && !flush;
    assign last_write = pop && (wr_count_q == LastPixel);

    // RAM port follows the current-cycle grant
    assign bus.ram_we     = pop;
    assign bus.ram_addr   = pop ? wr_count_q : bus.disp_addr;
    assign bus.ram_wdata  = fifo_mem[rd_ptr];
    assign bus.wr_ready   = !fifo_full;

    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.loading    = loading_q;
    assign bus.frame_done = frame_done_q;
    assign bus.abort      = abort_q;

    // Upload sequencing next-state and timeout counter next value
    always_comb begin
        state_next = state;
        tmo_next   = tmo_cnt;
        case (state)
            IDLE:    if (push) state_next = LOAD;
            LOAD: begin
                if (last_write)   state_next = DONE;
                else if (tmo_hit) state_next = ABORT;
            end
            DONE:    state_next = (!fifo_empty || push) ? LOAD : IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if ((state != LOAD) || (state_next != LOAD) || push) tmo_next = '0;
        else                                                 tmo_next = tmo_cnt + TmoWidth'(1);
    end

    // State register and registered status outputs
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            loading_q    <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state        <= state_next;
            tmo_cnt      <= tmo_next;
            loading_q    <= (state_next == LOAD);
            frame_done_q <= last_write;
            abort_q      <= (state_next == ABORT);
        end
    end

    // FIFO pointers and occupancy; abort empties the buffer
    always_ff @(posedge clk_in) begin
        if (reset || flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CntWidth'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CntWidth'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr] <= bus.wr_data;
    end

    // Raster write pointer with wrap at the last pixel
    always_ff @(posedge clk_in) begin
        if (reset || flush) wr_count_q <= '0;
        else if (pop)       wr_count_q <= last_write ? '0 : wr_count_q + AddressWidth'(1);
    end

    // Two-stage read return: RAM latency plus output register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rd_pipe      <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            rd_pipe      <= bus.disp_req;
            disp_valid_q <= rd_pipe;
            if (rd_pipe) disp_data_q <= bus.ram_rdata;
        end
    end
endmodule

// File: tb/tb_img_ram_arbiter.sv
// Scoreboard bench for img_ram_arbiter: stimulus pushes expected reads and
// RAM writes into queues, a negedge monitor pops and compares them.
module tb_img_ram_arbiter;
    localparam int unsigned AW  = 14;
    localparam int unsigned DW  = 8;
    localparam int unsigned PIX = 10000;
    localparam int unsigned TMO = 50;
    localparam logic [AW-1:0] STALL_ADDR = 14'd16000;

    typedef struct packed {
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic clk_in = 1'b0;
    logic reset;
    always #5 clk_in = ~clk_in;

    img_ram_arbiter_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

    img_ram_arbiter #(
        .AddressWidth(AW), .DataWidth(DW), .PIXELS(PIX),
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous RAM model with a bench preload port
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge clk_in) begin
        if (pre_we)           mem[pre_addr] <= pre_data;
        else if (bus.ram_we)  mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    rd_exp_t exp_rd[$];
    wr_exp_t exp_wr[$];
    int      n_chk = 0;
    int      n_pass = 0;
    int      fd_cnt = 0;
    int      abort_cnt = 0;
    int      abort_cyc = 0;
    int      last_push_cyc = 0;
    logic    mon_en = 1'b0;
    logic [AW-1:0] exp_ptr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // One clock of stimulus; expectations are supplied by the caller
    task automatic drive(input logic req, input logic [AW-1:0] a, input logic [DW-1:0] rexp,
                         input logic vld, input logic [DW-1:0] d, input logic acc,
                         input logic wexp);
        @(posedge clk_in);
        #1;
        bus.disp_req  = req;
        bus.disp_addr = a;
        bus.wr_valid  = vld;
        bus.wr_data   = d;
        if (req) exp_rd.push_back(rd_exp_t'{data: rexp, cyc: cyc + 2});
        if (vld) begin
            check("wr_ready", 32'(bus.wr_ready), 32'(acc));
            if (acc) last_push_cyc = cyc;
            if (acc && wexp) begin
                exp_wr.push_back(wr_exp_t'{addr: exp_ptr, data: d});
                exp_ptr = (exp_ptr == AW'(PIX - 1)) ? '0 : exp_ptr + 14'd1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented read and write against the queues
    initial begin
        rd_exp_t r;
        wr_exp_t w;
        forever begin
            @(negedge clk_in);
            if (mon_en) begin
                if (bus.disp_valid === 1'b1) begin
                    if (exp_rd.size() == 0) check("read_unexpected", 32'(bus.disp_valid), 32'd0);
                    else begin
                        r = exp_rd.pop_front();
                        check("read_data", 32'(bus.disp_data), 32'(r.data));
                        check("read_cycle", 32'(cyc), 32'(r.cyc));
                    end
                end
                if (bus.disp_req === 1'b1) begin
                    check("stall_we", 32'(bus.ram_we), 32'd0);
                    check("read_addr", 32'(bus.ram_addr), 32'(bus.disp_addr));
                end
                if (bus.ram_we === 1'b1) begin
                    if (exp_wr.size() == 0) check("write_unexpected", 32'(bus.ram_we), 32'd0);
                    else begin
                        w = exp_wr.pop_front();
                        check("write_addr", 32'(bus.ram_addr), 32'(w.addr));
                        check("write_data", 32'(bus.ram_wdata), 32'(w.data));
                    end
                end
                if (bus.frame_done === 1'b1) fd_cnt++;
                if (bus.abort === 1'b1) begin
                    abort_cnt++;
                    abort_cyc = cyc;
                    check("abort_wr_count", 32'(bus.wr_count), 32'd0);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        pre_we        = 1'b0;
        pre_addr      = '0;
        pre_data      = '0;
        exp_ptr       = '0;

        // Preload RAM while held in reset
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in);
            #1;
            pre_we   = 1'b1;
            pre_addr = (k == 3) ? STALL_ADDR : AW'(k);
            pre_data = (k == 3) ? 8'hA5 : DW'(8'h11 * (k + 1));
        end
        @(posedge clk_in);
        #1;
        pre_we = 1'b0;
        @(posedge clk_in);
        #1;
        check("rst_disp_data",  32'(bus.disp_data),  32'd0);
        check("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
        check("rst_wr_count",   32'(bus.wr_count),   32'd0);
        check("rst_loading",    32'(bus.loading),    32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_abort",      32'(bus.abort),      32'd0);
        check("rst_wr_ready",   32'(bus.wr_ready),   32'd1);
        check("rst_ram_we",     32'(bus.ram_we),     32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Read path: three back-to-back reads
        drive(1'b1, 14'd0, 8'h11, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 14'd1, 8'h22, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 14'd2, 8'h33, 1'b0, '0, 1'b0, 1'b0);
        idle(4);
        check("read_drain", 32'(exp_rd.size()), 32'd0);

        // Contention: writes held off while display reads for 10 cycles
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, STALL_ADDR, 8'hA5, (i < 3), DW'(8'hC0 + i), 1'b1, 1'b1);
            if (i == 5) check("loading_after_push", 32'(bus.loading), 32'd1);
        end
        idle(5);
        check("contention_drain", 32'(exp_wr.size()), 32'd0);
        check("contention_wr_count", 32'(bus.wr_count), 32'd3);

        // Overflow: fifth byte offered into a full FIFO is dropped
        for (int i = 0; i < 5; i++)
            drive(1'b1, STALL_ADDR, 8'hA5, 1'b1, DW'(8'hD0 + i), (i < 4), (i < 4));
        idle(6);
        check("overflow_drain", 32'(exp_wr.size()), 32'd0);
        check("overflow_wr_count", 32'(bus.wr_count), 32'd7);

        // Timeout: abort 50 cycles after the last accepted byte
        idle(60);
        check("abort_count", 32'(abort_cnt), 32'd1);
        check("abort_timing", 32'(abort_cyc), 32'(last_push_cyc + 51));
        check("abort_wr_count_after", 32'(bus.wr_count), 32'd0);
        check("abort_loading", 32'(bus.loading), 32'd0);
        exp_ptr = '0;

        // Full frame from address 0
        fd_cnt = 0;
        for (int i = 0; i < int'(PIX); i++) begin
            drive(1'b0, '0, '0, 1'b1, DW'(i), 1'b1, 1'b1);
            if (i == 5000) check("frame_loading", 32'(bus.loading), 32'd1);
        end
        idle(5);
        check("frame_done_count", 32'(fd_cnt), 32'd1);
        check("frame_wr_count", 32'(bus.wr_count), 32'd0);
        check("frame_loading_end", 32'(bus.loading), 32'd0);
        check("frame_last_pixel", 32'(mem[PIX-1]), 32'h0F);
        check("frame_first_pixel", 32'(mem[0]), 32'h00);
        check("frame_drain", 32'(exp_wr.size()), 32'd0);

        // Reset mid-load: 20 written, 2 queued behind display reads
        for (int i = 0; i < 20; i++) drive(1'b0, '0, '0, 1'b1, DW'(8'h40 + i), 1'b1, 1'b1);
        idle(2);
        drive(1'b1, STALL_ADDR, 8'hA5, 1'b1, 8'h60, 1'b1, 1'b0);
        drive(1'b1, STALL_ADDR, 8'hA5, 1'b1, 8'h61, 1'b1, 1'b0);
        drive(1'b1, STALL_ADDR, 8'hA5, 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        exp_rd.delete();
        exp_ptr = '0;
        check("rstmid_wr_count", 32'(bus.wr_count), 32'd0);
        check("rstmid_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rstmid_loading", 32'(bus.loading), 32'd0);
        check("rstmid_disp_valid", 32'(bus.disp_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
            check("rstmid_no_write", 32'(bus.ram_we), 32'd0);
        end
        check("rstmid_pixel19", 32'(mem[19]), 32'h53);
        check("rstmid_wr_queue", 32'(exp_wr.size()), 32'd0);

        check("final_rd_queue", 32'(exp_rd.size()), 32'd0);
        check("final_frame_done", 32'(fd_cnt), 32'd1);
        check("final_abort", 32'(abort_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
